// File: rtl/disp_arbiter.sv
// Round-robin owner of the shared four-digit seven-segment driver: three requesters,
// a minimum and maximum dwell, and a one-cycle blank gap between owners.
module disp_arbiter #(
  parameter int MIN_HOLD = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [47:0] data_in,
  output logic [2:0]  gnt,
  output logic [15:0] bcd_out,
  output logic        busy,
  output logic        switch_p
);

  localparam int DW = $clog2(MAX_HOLD + 1);
  localparam logic [15:0] BLANK = 16'hFFFF;

  typedef enum logic [1:0] {IDLE, LOCKED, OPEN} state_t;

  state_t        state;
  logic [1:0]    owner;
  logic [1:0]    ptr;
  logic [DW-1:0] dwell;

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  function automatic logic [2:0] one_hot(input logic [1:0] i);
    case (i)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Round-robin search starting at ptr; only consulted in IDLE.
  logic       found;
  logic [1:0] winner;
  logic [1:0] cand;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    cand   = ptr;
    for (int k = 0; k < 3; k++) begin
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
      cand = next_idx(cand);
    end
  end

  logic [15:0] lane;
  always_comb begin
    case (owner)
      2'd0:    lane = data_in[15:0];
      2'd1:    lane = data_in[31:16];
      2'd2:    lane = data_in[47:32];
      default: lane = BLANK;
    endcase
  end

  // LOCKED turns into OPEN behaviour on the very cycle dwell reaches MIN_HOLD.
  logic [2:0] owner_mask;
  logic       owner_req;
  logic       others_req;
  logic       open_phase;
  logic       release_now;

  always_comb begin
    owner_mask  = one_hot(owner);
    owner_req   = |(req & owner_mask);
    others_req  = |(req & ~owner_mask);
    open_phase  = (state == OPEN) || (state == LOCKED && dwell >= DW'(MIN_HOLD));
    release_now = open_phase && (!owner_req || (dwell >= DW'(MAX_HOLD) && others_req));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= 2'd0;
      ptr      <= 2'd0;
      dwell    <= '0;
      gnt      <= 3'b000;
      bcd_out  <= BLANK;
      busy     <= 1'b0;
      switch_p <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bcd_out <= BLANK;
          if (found) begin
            state    <= LOCKED;
            owner    <= winner;
            ptr      <= next_idx(winner);
            dwell    <= DW'(1);
            gnt      <= one_hot(winner);
            busy     <= 1'b1;
            switch_p <= 1'b1;
          end else begin
            gnt      <= 3'b000;
            busy     <= 1'b0;
            switch_p <= 1'b0;
          end
        end
        LOCKED, OPEN: begin
          switch_p <= 1'b0;
          if (release_now) begin
            state   <= IDLE;
            dwell   <= '0;
            gnt     <= 3'b000;
            busy    <= 1'b0;
            bcd_out <= BLANK;
          end else begin
            bcd_out <= lane;
            if (dwell < DW'(MAX_HOLD)) dwell <= dwell + DW'(1);
            if (state == LOCKED && dwell >= DW'(MIN_HOLD)) state <= OPEN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_disp_arbiter.sv
// Directed bench for disp_arbiter: the driver queues hand-computed per-cycle
// expectations and a monitor compares them one cycle-edge later.
module tb_disp_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [47:0] data_in;
  logic [2:0]  gnt;
  logic [15:0] bcd_out;
  logic        busy;
  logic        switch_p;

  logic [15:0] lane0, lane1, lane2;

  typedef struct packed {
    logic [2:0]  gnt;
    logic [15:0] bcd;
    logic        busy;
    logic        sw;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_no = 0;

  disp_arbiter #(.MIN_HOLD(4), .MAX_HOLD(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data_in  (data_in),
    .gnt      (gnt),
    .bcd_out  (bcd_out),
    .busy     (busy),
    .switch_p (switch_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs are those visible after the posedge that samples these inputs.
  task automatic step(input logic r, input logic [2:0] rq,
                      input logic [2:0] eg, input logic [15:0] eb, input logic es);
    exp_t e;
    @(negedge clk);
    rst     = r;
    req     = rq;
    data_in = {lane2, lane1, lane0};
    e.gnt   = eg;
    e.bcd   = eb;
    e.busy  = |eg;
    e.sw    = es;
    exp_q.push_back(e);
  endtask

  task automatic rep(input int n, input logic r, input logic [2:0] rq,
                     input logic [2:0] eg, input logic [15:0] eb, input logic es);
    for (int i = 0; i < n; i++) step(r, rq, eg, eb, es);
  endtask

  task automatic check(input exp_t e);
    checks++;
    if ({gnt, bcd_out, busy, switch_p} !== e) begin
      errors++;
      $display("FAIL vec_%0d: got gnt=%b bcd=%h busy=%b sw=%b, want gnt=%b bcd=%h busy=%b sw=%b",
               vec_no, gnt, bcd_out, busy, switch_p, e.gnt, e.bcd, e.busy, e.sw);
    end
    vec_no++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e);
      end
    end
  end

  initial begin : driver
    rst   = 1'b1;
    req   = 3'b111;
    lane0 = 16'h0001;
    lane1 = 16'h1234;
    lane2 = 16'h5678;
    data_in = {lane2, lane1, lane0};

    // Reset held with all requests: stays blank, then requester 0 wins first.
    rep(2, 1'b1, 3'b111, 3'b000, 16'hFFFF, 1'b0);
    step(1'b0, 3'b111, 3'b001, 16'hFFFF, 1'b1);
    rep(3, 1'b0, 3'b000, 3'b001, 16'h0001, 1'b0);
    step(1'b0, 3'b000, 3'b000, 16'hFFFF, 1'b0);

    // Minimum dwell: one-cycle request on lane 1 still gets four grant cycles.
    step(1'b0, 3'b010, 3'b010, 16'hFFFF, 1'b1);
    rep(3, 1'b0, 3'b000, 3'b010, 16'h1234, 1'b0);
    step(1'b0, 3'b000, 3'b000, 16'hFFFF, 1'b0);
    step(1'b0, 3'b000, 3'b000, 16'hFFFF, 1'b0);

    // Preemption at MAX_HOLD with 0 and 1 both requesting.
    step(1'b0, 3'b011, 3'b001, 16'hFFFF, 1'b1);
    rep(7, 1'b0, 3'b011, 3'b001, 16'h0001, 1'b0);
    step(1'b0, 3'b011, 3'b000, 16'hFFFF, 1'b0);
    step(1'b0, 3'b011, 3'b010, 16'hFFFF, 1'b1);
    rep(7, 1'b0, 3'b011, 3'b010, 16'h1234, 1'b0);
    step(1'b0, 3'b011, 3'b000, 16'hFFFF, 1'b0);
    step(1'b0, 3'b011, 3'b001, 16'hFFFF, 1'b1);
    rep(7, 1'b0, 3'b011, 3'b001, 16'h0001, 1'b0);
    step(1'b0, 3'b000, 3'b000, 16'hFFFF, 1'b0);

    // Round-robin wrap: serve 2, then 0 beats 2, then 2 beats 0.
    step(1'b0, 3'b100, 3'b100, 16'hFFFF, 1'b1);
    rep(3, 1'b0, 3'b000, 3'b100, 16'h5678, 1'b0);
    step(1'b0, 3'b000, 3'b000, 16'hFFFF, 1'b0);
    step(1'b0, 3'b101, 3'b001, 16'hFFFF, 1'b1);
    rep(3, 1'b0, 3'b100, 3'b001, 16'h0001, 1'b0);
    step(1'b0, 3'b100, 3'b000, 16'hFFFF, 1'b0);
    step(1'b0, 3'b101, 3'b100, 16'hFFFF, 1'b1);
    rep(3, 1'b0, 3'b000, 3'b100, 16'h5678, 1'b0);
    step(1'b0, 3'b000, 3'b000, 16'hFFFF, 1'b0);

    // Live data on lane 0, then owner drops its request in OPEN.
    step(1'b0, 3'b001, 3'b001, 16'hFFFF, 1'b1);
    step(1'b0, 3'b001, 3'b001, 16'h0001, 1'b0);
    lane0 = 16'h0042;
    step(1'b0, 3'b001, 3'b001, 16'h0042, 1'b0);
    step(1'b0, 3'b001, 3'b001, 16'h0042, 1'b0);
    step(1'b0, 3'b001, 3'b001, 16'h0042, 1'b0);
    step(1'b0, 3'b000, 3'b000, 16'hFFFF, 1'b0);

    // Reset in LOCKED cycle 2; afterwards ptr is 0 so requester 1 beats 2.
    step(1'b0, 3'b010, 3'b010, 16'hFFFF, 1'b1);
    step(1'b0, 3'b010, 3'b010, 16'h1234, 1'b0);
    step(1'b1, 3'b010, 3'b000, 16'hFFFF, 1'b0);
    lane1 = 16'hFACE;
    step(1'b0, 3'b110, 3'b010, 16'hFFFF, 1'b1);
    rep(3, 1'b0, 3'b000, 3'b010, 16'hFACE, 1'b0);
    step(1'b0, 3'b000, 3'b000, 16'hFFFF, 1'b0);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
